// File: rtl/spi_reg_slave.sv
// spi_reg_slave: oversampled SPI slave (modes 0-3) giving a host access to a DEPTH x DATA_W register file
// through a command byte followed by auto-incrementing data words.
module spi_reg_slave #(
    parameter int DATA_W = 8,
    parameter int DEPTH = 4,
    parameter int CPOL = 0,
    parameter int CPHA = 0,
    parameter int SYNC_STAGES = 2,
    localparam int ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    sck,
    input  logic                    cs,
    input  logic                    mosi,
    output logic                    miso,
    output logic                    miso_oe,
    output logic [DEPTH*DATA_W-1:0] regs_q,
    output logic                    wr_stb,
    output logic [ADDR_W-1:0]       wr_addr,
    output logic [DATA_W-1:0]       wr_data,
    output logic                    frame_err,
    output logic                    busy
);
    localparam int SW = (DATA_W > 8) ? DATA_W : 8;
    localparam logic [7:0] DEPTH8 = 8'(DEPTH);
    localparam logic [5:0] LAST_D = 6'(DATA_W - 1);
    localparam logic [2:0] SYNC_RST = {(CPOL != 0), 1'b0, 1'b0};

    typedef enum logic [1:0] {IDLE, CMD, DATA} state_t;

    state_t                         state_q, state_d;
    logic [SYNC_STAGES-1:0][2:0]    sync_q;
    logic                           sck_d1_q, armed_q;
    logic [5:0]                     cnt_q, cnt_d;
    logic [SW-2:0]                  rx_q, rx_d;
    logic [SW-1:0]                  rx_nx;
    logic [DATA_W-1:0]              tx_q, tx_d, rd_word;
    logic [6:0]                     addr_q, addr_d, addr_nx;
    logic                           rd_q, rd_d;
    logic [DEPTH-1:0][DATA_W-1:0]   mem_q, mem_d;
    logic                           wr_stb_q, wr_stb_d, frame_err_q, frame_err_d;
    logic [ADDR_W-1:0]              wr_addr_q, wr_addr_d;
    logic [DATA_W-1:0]              wr_data_q, wr_data_d;
    logic                           sck_s, cs_s, mosi_s, lead, trail, sample_stb, shift_stb;
    logic                           word_done, wr_ok;

    assign {sck_s, cs_s, mosi_s} = sync_q[SYNC_STAGES-1];
    assign lead = (CPOL != 0) ? (sck_d1_q & ~sck_s) : (sck_s & ~sck_d1_q);
    assign trail = (sck_s ^ sck_d1_q) & ~lead;
    assign sample_stb = (CPHA != 0) ? trail : lead;
    assign shift_stb = (CPHA != 0) ? lead : trail;
    assign rx_nx = {rx_q, mosi_s};
    assign word_done = (state_q == CMD) ? (cnt_q == 6'd7) : (cnt_q == LAST_D);
    assign addr_nx = (state_q == CMD) ? rx_nx[6:0] : addr_q + 7'd1;
    assign rd_word = ({1'b0, addr_nx} < DEPTH8) ? mem_q[addr_nx[ADDR_W-1:0]] : '0;
    assign wr_ok = ({1'b0, addr_q} < DEPTH8) && !rd_q;

    // armed_q blocks a frame that was already in progress when reset released
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q      <= {SYNC_STAGES{SYNC_RST}};
            sck_d1_q    <= (CPOL != 0);
            armed_q     <= 1'b0;
            state_q     <= IDLE;
            cnt_q       <= '0;
            rx_q        <= '0;
            tx_q        <= '0;
            addr_q      <= '0;
            rd_q        <= 1'b0;
            mem_q       <= '0;
            wr_stb_q    <= 1'b0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
            frame_err_q <= 1'b0;
        end else begin
            sync_q      <= {sync_q[SYNC_STAGES-2:0], {sck, cs, mosi}};
            sck_d1_q    <= sck_s;
            armed_q     <= armed_q | cs_s;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rx_q        <= rx_d;
            tx_q        <= tx_d;
            addr_q      <= addr_d;
            rd_q        <= rd_d;
            mem_q       <= mem_d;
            wr_stb_q    <= wr_stb_d;
            wr_addr_q   <= wr_addr_d;
            wr_data_q   <= wr_data_d;
            frame_err_q <= frame_err_d;
        end
    end

    // A shift edge with cnt_q == 0 would precede the first sample of a freshly loaded word, so it is skipped.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        rx_d        = rx_q;
        tx_d        = tx_q;
        addr_d      = addr_q;
        rd_d        = rd_q;
        mem_d       = mem_q;
        wr_stb_d    = 1'b0;
        wr_addr_d   = wr_addr_q;
        wr_data_d   = wr_data_q;
        frame_err_d = 1'b0;
        if (cs_s) begin
            frame_err_d = (state_q != IDLE) && (cnt_q != '0);
            state_d     = IDLE;
            cnt_d       = '0;
        end else if (state_q == IDLE) begin
            state_d = armed_q ? CMD : IDLE;
        end else if (sample_stb) begin
            rx_d  = rx_nx[SW-2:0];
            cnt_d = word_done ? '0 : cnt_q + 6'd1;
            if (word_done) begin
                state_d = DATA;
                addr_d  = addr_nx;
                tx_d    = rd_word;
                if (state_q == CMD) begin
                    rd_d = rx_nx[7];
                end else if (wr_ok) begin
                    wr_stb_d                      = 1'b1;
                    wr_addr_d                     = addr_q[ADDR_W-1:0];
                    wr_data_d                     = rx_nx[DATA_W-1:0];
                    mem_d[addr_q[ADDR_W-1:0]]     = rx_nx[DATA_W-1:0];
                end
            end
        end else if (shift_stb && cnt_q != '0) begin
            tx_d = tx_q << 1;
        end
    end

    assign regs_q    = mem_q;
    assign busy      = state_q != IDLE;
    assign miso_oe   = busy;
    assign miso      = (state_q == DATA) & rd_q & tx_q[DATA_W-1];
    assign wr_stb    = wr_stb_q;
    assign wr_addr   = wr_addr_q;
    assign wr_data   = wr_data_q;
    assign frame_err = frame_err_q;
endmodule

// File: tb/tb_spi_reg_slave.sv
// tb_spi_reg_slave: one spi_reg_slave per SPI mode, driven by directed and random frames and
// checked against a register-file model of the command/burst protocol.
module tb_spi_reg_slave;
    localparam int DW = 8, DEP = 4, AW = 2, H = 80;

    logic clk = 1'b0, rst = 1'b1;
    logic [3:0] sck, cs, mosi, miso, miso_oe, wr_stb, frame_err, busy;
    logic [DEP*DW-1:0] regs [4];
    logic [AW-1:0] wr_addr [4];
    logic [DW-1:0] wr_data [4];
    logic [DW-1:0] mdl [4][DEP];
    logic [DW-1:0] txw [16];
    logic [AW+DW+1:0] wq [$];
    logic [AW+DW+1:0] eq [$];
    int fe_cnt [4] = '{default: 0};
    int n_cmp = 0, n_err = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 4; g++) begin : g_dut
        spi_reg_slave #(
            .DATA_W(DW), .DEPTH(DEP), .CPOL(g / 2), .CPHA(g % 2), .SYNC_STAGES(2)
        ) u_dut (
            .clk(clk), .rst(rst), .sck(sck[g]), .cs(cs[g]), .mosi(mosi[g]),
            .miso(miso[g]), .miso_oe(miso_oe[g]), .regs_q(regs[g]), .wr_stb(wr_stb[g]),
            .wr_addr(wr_addr[g]), .wr_data(wr_data[g]), .frame_err(frame_err[g]), .busy(busy[g])
        );
    end

    always @(negedge clk)
        for (int i = 0; i < 4; i++) begin
            if (wr_stb[i]) wq.push_back({2'(i), wr_addr[i], wr_data[i]});
            if (frame_err[i]) fe_cnt[i] = fe_cnt[i] + 1;
        end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [DEP*DW-1:0] packed_mdl(input int m);
        logic [DEP*DW-1:0] r;
        for (int i = 0; i < DEP; i++) r[i*DW +: DW] = mdl[m][i];
        return r;
    endfunction

    task automatic xfer(input int m, input logic [31:0] val, input int n, output logic [31:0] rx, output logic oe);
        logic cp, ph;
        cp = (m >= 2);
        ph = (m % 2 == 1);
        rx = '0;
        oe = 1'b1;
        for (int b = n - 1; b >= 0; b--) begin
            if (ph) sck[m] = ~cp;
            mosi[m] = val[b];
            #(H);
            rx = {rx[30:0], miso[m]};
            oe &= miso_oe[m];
            sck[m] = ph ? cp : ~cp;
            #(H);
            if (!ph) sck[m] = cp;
        end
    endtask

    task automatic frame(input int m, input logic [7:0] cmd, input int nw, input int part);
        int a, fe0;
        logic [31:0] rx;
        logic oe, oe_all;
        logic [DW-1:0] e;
        fe0 = fe_cnt[m];
        wq.delete();
        eq.delete();
        a = int'(cmd[6:0]);
        cs[m] = 1'b0;
        #(H);
        xfer(m, 32'(cmd), 8, rx, oe_all);
        for (int k = 0; k < nw; k++) begin
            xfer(m, 32'(txw[k]), DW, rx, oe);
            oe_all &= oe;
            if (cmd[7]) begin
                e = (a < DEP) ? mdl[m][a] : '0;
                check("rd_data", 64'(rx[DW-1:0]), 64'(e));
            end else if (a < DEP) begin
                mdl[m][a] = txw[k];
                eq.push_back({2'(m), AW'(a), txw[k]});
            end
            a = (a + 1) % 128;
        end
        if (part > 0) begin
            xfer(m, 32'(txw[nw]), part, rx, oe);
            oe_all &= oe;
        end
        #(H);
        cs[m] = 1'b1;
        repeat (16) @(negedge clk);
        check("oe_in_frame", 64'(oe_all), 64'(1));
        check("oe_after", 64'(miso_oe[m]), 64'(0));
        check("busy_after", 64'(busy[m]), 64'(0));
        check("frame_err", 64'(fe_cnt[m] - fe0), 64'(part > 0));
        check("wr_count", 64'(wq.size()), 64'(eq.size()));
        for (int k = 0; k < eq.size() && k < wq.size(); k++) check("wr_entry", 64'(wq[k]), 64'(eq[k]));
        check("regs", 64'(regs[m]), 64'(packed_mdl(m)));
    endtask

    initial begin
        int m, nw, part;
        logic [7:0] cmd;
        logic [31:0] rx;
        logic oe;
        sck = 4'b1100;
        cs = 4'hF;
        mosi = 4'h0;
        for (int i = 0; i < 4; i++) for (int j = 0; j < DEP; j++) mdl[i][j] = '0;
        repeat (4) @(negedge clk);
        for (int i = 0; i < 4; i++) check("rst_regs", 64'(regs[i]), 64'(0));
        check("rst_miso", 64'(miso), 64'(0));
        check("rst_oe", 64'(miso_oe), 64'(0));
        check("rst_stb", 64'({wr_stb, frame_err, busy}), 64'(0));
        check("rst_wr", 64'({wr_addr[0], wr_data[0], wr_addr[3], wr_data[3]}), 64'(0));
        rst = 1'b0;
        repeat (8) @(negedge clk);

        for (int i = 0; i < 4; i++) begin
            txw[0] = 8'hA5;
            txw[1] = 8'h3C;
            frame(i, 8'h01, 2, 0);
            check("tp_regs", 64'(regs[i]), 64'h003CA500);
            frame(i, 8'h81, 2, 0);
        end

        txw[0] = 8'h11;
        txw[1] = 8'h22;
        frame(0, 8'h03, 2, 0);
        check("wrap_top", 64'(regs[0][31:24]), 64'h11);
        txw[0] = 8'hEE;
        frame(0, 8'h00, 0, 5);
        frame(0, 8'h80, 4, 0);

        for (int t = 0; t < 30; t++) begin
            m = $urandom_range(0, 3);
            cmd[7] = 1'($urandom_range(0, 1));
            cmd[6:0] = ($urandom_range(0, 3) == 0) ? 7'(124 + $urandom_range(0, 3)) : 7'($urandom_range(0, 7));
            nw = $urandom_range(0, 4);
            part = ($urandom_range(0, 4) == 0) ? $urandom_range(1, DW - 1) : 0;
            for (int k = 0; k < 16; k++) txw[k] = DW'($urandom);
            frame(m, cmd, nw, part);
        end

        m = $urandom_range(0, 3);
        cs[m] = 1'b0;
        #(H);
        xfer(m, 32'h80, 8, rx, oe);
        xfer(m, 32'h0, 3, rx, oe);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) for (int j = 0; j < DEP; j++) mdl[i][j] = '0;
        wq.delete();
        xfer(m, 32'h01, 8, rx, oe);
        xfer(m, 32'h5A, 8, rx, oe);
        check("rst_mid_wr", 64'(wq.size()), 64'(0));
        check("rst_mid_regs", 64'(regs[m]), 64'(0));
        check("rst_mid_miso", 64'(miso[m]), 64'(0));
        check("rst_mid_busy", 64'(busy[m]), 64'(0));
        cs[m] = 1'b1;
        repeat (16) @(negedge clk);
        txw[0] = 8'h77;
        txw[1] = 8'h99;
        frame(m, 8'h02, 2, 0);
        frame(m, 8'h82, 2, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
